// File: rtl/motoro3_line_calc_param_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motoro3_line_calc_param_seq_if                                             |
// | Request/result bundle between step sequencer, line calculator and PWM.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface motoro3_line_calc_param_seq_if #(
  parameter int PWM_W  = 8,
  parameter int STEP_W = 4
);
  logic              calcReq;
  logic [PWM_W-1:0]  pwmLen;
  logic [PWM_W-1:0]  pwmMin;
  logic [STEP_W-1:0] lcStep;
  logic              busy;
  logic              calcDone;
  logic              stepErr;
  logic [8:0]        slLenU;
  logic [8:0]        slLenV;
  logic [8:0]        slLenW;
  logic [PWM_W-1:0]  plLenU;
  logic [PWM_W-1:0]  plLenV;
  logic [PWM_W-1:0]  plLenW;

  modport master (
    output calcReq, pwmLen, pwmMin, lcStep,
    input  busy, calcDone, stepErr, slLenU, slLenV, slLenW, plLenU, plLenV, plLenW
  );

  modport slave (
    input  calcReq, pwmLen, pwmMin, lcStep,
    output busy, calcDone, stepErr, slLenU, slLenV, slLenW, plLenU, plLenV, plLenW
  );
endinterface
`default_nettype wire

// File: rtl/motoro3_line_calc_param_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motoro3_line_calc_param_seq                                                |
// | Sequential 3-phase sine/PWM on-length calculator with one shared           |
// | shift-add multiplier. Optional clamp: MOTORO3_LCP_DEADBAND_EN.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module motoro3_line_calc_param_seq #(
  parameter int PWM_W    = 8,
  parameter int STEP_NUM = 12,
  parameter int STEP_W   = 4,
  parameter int DEAD_LEN = 2
) (
  input  wire logic                    clk,
  input  wire logic                    nRst,
  motoro3_line_calc_param_seq_if.slave bus
);
  localparam int PW = PWM_W + 9;
  localparam int IW = STEP_W + 2;
  localparam logic [IW-1:0] c_STEP_NUM = IW'(STEP_NUM);
  localparam logic [IW-1:0] c_THIRD    = IW'(STEP_NUM / 3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic [1:0]        ph_q;
  logic [PW-1:0]     acc_q;
  logic [PWM_W-1:0]  len_q, min_q;
  logic [STEP_W-1:0] step_q;
  logic              err_q;
  logic [PWM_W-1:0]  pl_q    [3];
  logic [8:0]        sl_q    [3];
  logic [PWM_W-1:0]  plOut_q [3];
  logic [8:0]        slOut_q [3];
  logic              busy_q, done_q, stepErr_q;

  function automatic logic [8:0] sine(input logic [IW-1:0] idx);
    logic [8:0] v;
    v = '0;
    if (STEP_NUM == 12) begin
      case (int'(idx))
        1, 5, 7, 11: v = 9'd128;
        2, 4, 8, 10: v = 9'd222;
        3, 9:        v = 9'd256;
        default:     v = 9'd0;
      endcase
    end else begin
      case (int'(idx))
        1, 2, 4, 5: v = 9'd222;
        default:    v = 9'd0;
      endcase
    end
    return v;
  endfunction

  function automatic logic [PWM_W-1:0] clampf(input logic [PWM_W-1:0] p);
`ifdef MOTORO3_LCP_DEADBAND_EN
    logic [PWM_W-1:0] lim;
    lim = (len_q > PWM_W'(DEAD_LEN)) ? len_q - PWM_W'(DEAD_LEN) : '0;
    // pwmMin takes precedence when the clearance limit falls below it
    if (p > lim) return (lim < min_q) ? min_q : lim;
    return p;
`else
    return p;
`endif
  endfunction

  logic [PWM_W-1:0] w_d;
  logic [IW-1:0]    w_off, w_sum, w_idx;
  logic [8:0]       w_sl;
  logic             w_bit;
  logic [PW-1:0]    w_addend;
  logic [PWM_W:0]   w_plSum;
  logic [PWM_W-1:0] w_pl;

  assign w_d      = (len_q > min_q) ? len_q - min_q : '0;
  assign w_off    = (ph_q == 2'd1) ? c_THIRD : (ph_q == 2'd2) ? (c_THIRD + c_THIRD) : '0;
  assign w_sum    = IW'(step_q) + w_off;
  assign w_idx    = (w_sum >= c_STEP_NUM) ? w_sum - c_STEP_NUM : w_sum;
  assign w_sl     = err_q ? 9'd0 : sine(w_idx);
  assign w_bit    = (cnt_q < 4'd9) ? w_sl[cnt_q] : 1'b0;
  assign w_addend = w_bit ? (PW'(w_d) << cnt_q) : '0;
  assign w_plSum  = {1'b0, min_q} + acc_q[PW-1:8];
  assign w_pl     = w_plSum[PWM_W-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.calcReq) state_d = S_CALC;
      S_CALC:  if (cnt_q == 4'd9 && ph_q == 2'd2) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ph_q      <= '0;
      acc_q     <= '0;
      len_q     <= '0;
      min_q     <= '0;
      step_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      stepErr_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        pl_q[i]    <= '0;
        sl_q[i]    <= '0;
        plOut_q[i] <= '0;
        slOut_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.calcReq) begin
            len_q  <= bus.pwmLen;
            min_q  <= bus.pwmMin;
            step_q <= bus.lcStep;
            err_q  <= IW'(bus.lcStep) >= c_STEP_NUM;
            busy_q <= 1'b1;
            cnt_q  <= '0;
            ph_q   <= '0;
            acc_q  <= '0;
          end
        end
        S_CALC: begin
          // Nine LSB-first partial products, then one store cycle per phase
          if (cnt_q == 4'd9) begin
            pl_q[ph_q] <= w_pl;
            sl_q[ph_q] <= w_sl;
            acc_q      <= '0;
            cnt_q      <= '0;
            ph_q       <= ph_q + 2'd1;
          end else begin
            acc_q <= acc_q + w_addend;
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          for (int i = 0; i < 3; i++) begin
            plOut_q[i] <= clampf(pl_q[i]);
            slOut_q[i] <= sl_q[i];
          end
          stepErr_q <= err_q;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.calcDone = done_q;
  assign bus.stepErr  = stepErr_q;
  assign bus.slLenU   = slOut_q[0];
  assign bus.slLenV   = slOut_q[1];
  assign bus.slLenW   = slOut_q[2];
  assign bus.plLenU   = plOut_q[0];
  assign bus.plLenV   = plOut_q[1];
  assign bus.plLenW   = plOut_q[2];
endmodule
`default_nettype wire

// File: tb/tb_motoro3_line_calc_param_seq.sv
`default_nettype none
// Directed self-checking bench for motoro3_line_calc_param_seq (default parameters).
module tb_motoro3_line_calc_param_seq;
  logic clk;
  logic nRst;
  int   tests;
  int   failed;

  motoro3_line_calc_param_seq_if #(.PWM_W(8), .STEP_W(4)) bus ();

  motoro3_line_calc_param_seq #(
    .PWM_W(8), .STEP_NUM(12), .STEP_W(4), .DEAD_LEN(2)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MOTORO3_LCP_DEADBAND_EN
  localparam int EXP_W1 = 198;
`else
  localparam int EXP_W1 = 200;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input int len, input int mn, input int step);
    int lat;
    @(negedge clk);
    bus.pwmLen  = 8'(len);
    bus.pwmMin  = 8'(mn);
    bus.lcStep  = 4'(step);
    bus.calcReq = 1'b1;
    @(posedge clk);
    #1;
    bus.calcReq = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.calcDone) break;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd31);
  endtask

  task automatic chk_out(input string tag, input int e, input int su, input int sv, input int sw,
                         input int pu, input int pv, input int pw);
    chk({tag, "_stepErr"}, 32'(bus.stepErr), 32'(e));
    chk({tag, "_slU"}, 32'(bus.slLenU), 32'(su));
    chk({tag, "_slV"}, 32'(bus.slLenV), 32'(sv));
    chk({tag, "_slW"}, 32'(bus.slLenW), 32'(sw));
    chk({tag, "_plU"}, 32'(bus.plLenU), 32'(pu));
    chk({tag, "_plV"}, 32'(bus.plLenV), 32'(pv));
    chk({tag, "_plW"}, 32'(bus.plLenW), 32'(pw));
  endtask

  initial begin
    int doneCnt;
    tests   = 0;
    failed  = 0;
    nRst    = 1'b0;
    bus.calcReq = 1'b0;
    bus.pwmLen  = '0;
    bus.pwmMin  = '0;
    bus.lcStep  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.calcDone), 32'd0);
    chk_out("rst", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nRst = 1'b1;

    run_req("s1", 200, 40, 1);
    chk_out("s1", 0, 128, 128, 256, 120, 120, EXP_W1);
    @(posedge clk);
    #1;
    chk("s1_pulse", 32'(bus.calcDone), 32'd0);
    chk("s1_idle_busy", 32'(bus.busy), 32'd0);
    chk("s1_hold_plW", 32'(bus.plLenW), 32'(EXP_W1));

    run_req("s0", 200, 40, 0);
    chk_out("s0", 0, 0, 222, 222, 40, 178, 178);

    run_req("lt", 30, 40, 3);
    chk_out("lt", 0, 256, 128, 128, 40, 40, 40);

    run_req("err", 30, 40, 13);
    chk_out("err", 1, 0, 0, 0, 40, 40, 40);

    // Abort mid-calculation with asynchronous reset
    @(negedge clk);
    bus.pwmLen = 8'd200; bus.pwmMin = 8'd40; bus.lcStep = 4'd1; bus.calcReq = 1'b1;
    @(posedge clk);
    #1;
    bus.calcReq = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    nRst = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk_out("abort", 0, 0, 0, 0, 0, 0, 0);
    doneCnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.calcDone) doneCnt++;
    end
    @(negedge clk);
    nRst = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.calcDone) doneCnt++;
    end
    chk("abort_no_done", 32'(doneCnt), 32'd0);
    run_req("s2", 200, 40, 2);
    chk_out("s2", 0, 222, 0, 222, 178, 40, 178);

    // Held request, inputs changing every cycle; accepts at edges 0, 32, 64
    @(negedge clk);
    doneCnt = 0;
    bus.calcReq = 1'b1;
    bus.pwmLen  = 8'd200;
    bus.pwmMin  = 8'd40;
    bus.lcStep  = 4'd0;
    for (int n = 0; n < 96; n++) begin
      @(posedge clk);
      #1;
      if (bus.calcDone) doneCnt++;
      if (n == 0 || n == 32 || n == 64) chk($sformatf("held_busy_%0d", n), 32'(bus.busy), 32'd1);
      if (n == 31) chk_out("held0", 0, 0, 222, 222, 40, 178, 178);
      if (n == 63) chk_out("held32", 0, 222, 0, 222, 178, 40, 178);
      if (n == 95) chk_out("held64", 0, 222, 222, 0, 178, 178, 40);
      if (n == 31 || n == 63 || n == 95) chk($sformatf("held_done_%0d", n), 32'(bus.calcDone), 32'd1);
      @(negedge clk);
      bus.lcStep = 4'((n + 1) % 12);
      bus.pwmLen = ((n + 1) % 2 == 0) ? 8'd200 : 8'd100;
      bus.pwmMin = ((n + 1) % 2 == 0) ? 8'd40 : 8'd90;
    end
    bus.calcReq = 1'b0;
    chk("held_done_count", 32'(doneCnt), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
`default_nettype wire
